// File: rtl/apb3_cpuif_bridge.sv
// APB3 slave to register-block cpuif request/ack bridge.
// Registered request stage, stall hold, ack capture and response timeout.
module apb3_cpuif_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  s_apb_psel,
  input  logic                  s_apb_penable,
  input  logic                  s_apb_pwrite,
  input  logic [ADDR_WIDTH-1:0] s_apb_paddr,
  input  logic [DATA_WIDTH-1:0] s_apb_pwdata,
  output logic [DATA_WIDTH-1:0] s_apb_prdata,
  output logic                  s_apb_pready,
  output logic                  s_apb_pslverr,
  output logic                  cpuif_req,
  output logic                  cpuif_req_is_wr,
  output logic [ADDR_WIDTH-1:0] cpuif_addr,
  output logic [DATA_WIDTH-1:0] cpuif_wr_data,
  output logic [DATA_WIDTH-1:0] cpuif_wr_biten,
  input  logic                  cpuif_req_stall_wr,
  input  logic                  cpuif_req_stall_rd,
  input  logic                  cpuif_rd_ack,
  input  logic                  cpuif_rd_err,
  input  logic [DATA_WIDTH-1:0] cpuif_rd_data,
  input  logic                  cpuif_wr_ack,
  input  logic                  cpuif_wr_err
);

  localparam int AL = $clog2(DATA_WIDTH / 8);
  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~((ADDR_WIDTH'(1) << AL) - ADDR_WIDTH'(1));

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  stall;
  logic                  ack;
  logic                  err;
  logic [DATA_WIDTH-1:0] rdat;

  // Only the handshake matching the captured direction is honoured.
  assign stall = wr_q ? cpuif_req_stall_wr : cpuif_req_stall_rd;
  assign ack   = wr_q ? cpuif_wr_ack : cpuif_rd_ack;
  assign err   = wr_q ? cpuif_wr_err : cpuif_rd_err;
  assign rdat  = wr_q ? '0 : cpuif_rd_data;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    prdata_d  = '0;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_apb_psel && !s_apb_penable) begin
          wr_d    = s_apb_pwrite;
          addr_d  = s_apb_paddr & AMASK;
          wdata_d = s_apb_pwdata;
          req_d   = 1'b1;
          state_d = REQ;
        end else if (s_apb_psel && s_apb_penable) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = RESP;
        end
      end
      REQ: begin
        if (!stall) begin
          req_d = 1'b0;
          cnt_d = '0;
          if (ack) begin
            pready_d  = 1'b1;
            pslverr_d = err;
            prdata_d  = rdat;
            state_d   = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (ack) begin
          pready_d  = 1'b1;
          pslverr_d = err;
          prdata_d  = rdat;
          state_d   = RESP;
        end else if (TO_EN && cnt_q == TO_LAST) begin
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpuif_req       = req_q;
  assign cpuif_req_is_wr = wr_q;
  assign cpuif_addr      = addr_q;
  assign cpuif_wr_data   = wdata_q;
  assign cpuif_wr_biten  = {DATA_WIDTH{req_q}};
  assign s_apb_prdata    = prdata_q;
  assign s_apb_pready    = pready_q;
  assign s_apb_pslverr   = pslverr_q;

endmodule

// File: doc/apb3_cpuif_bridge.md
Name: apb3_cpuif_bridge

Overview:
Synthesizable APB3 slave that converts APB3 transfers into the register block's internal CPU-interface request/ack protocol. It sits directly downstream of an APB3 master (bus fabric or bench driver) and upstream of the generated register decode/readback logic. It adds a registered request stage, stall handling, ack capture and a response timeout, so a stuck register target cannot hang the bus.

Parameters:
DATA_WIDTH, 32, APB/cpuif data width in bits; must be 8, 16, 32 or 64.
ADDR_WIDTH, 32, APB/cpuif address width in bits.
TIMEOUT_CYCLES, 255, maximum cycles from request acceptance to ack before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
s_apb_psel  in  1  APB select
s_apb_penable  in  1  APB enable (access phase)
s_apb_pwrite  in  1  1=write, 0=read
s_apb_paddr  in  ADDR_WIDTH  byte address
s_apb_pwdata  in  DATA_WIDTH  write data
s_apb_prdata  out  DATA_WIDTH  read data
s_apb_pready  out  1  transfer complete
s_apb_pslverr  out  1  transfer error
cpuif_req  out  1  request valid
cpuif_req_is_wr  out  1  request is a write
cpuif_addr  out  ADDR_WIDTH  word-aligned address
cpuif_wr_data  out  DATA_WIDTH  write data
cpuif_wr_biten  out  DATA_WIDTH  write bit enables
cpuif_req_stall_wr  in  1  write request not accepted this cycle
cpuif_req_stall_rd  in  1  read request not accepted this cycle
cpuif_rd_ack  in  1  read response valid
cpuif_rd_err  in  1  read error, qualified by rd_ack
cpuif_rd_data  in  DATA_WIDTH  read data, qualified by rd_ack
cpuif_wr_ack  in  1  write response valid
cpuif_wr_err  in  1  write error, qualified by wr_ack

Behaviour:
- Interface: one clock `clk`; reset `arst_n` is asynchronous and active-low.
- Reset: all outputs are 0. State is IDLE and the timeout counter is 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- State machine: IDLE -> REQ -> WAIT -> RESP -> IDLE.
- IDLE:
  - On an edge with psel=1 and penable=0, capture pwrite, pwdata and address, then go to REQ.
  - Address capture: paddr with the low log2(DATA_WIDTH/8) bits forced to 0.
  - On an edge with psel=1 and penable=1 (no setup phase seen), go to RESP with the error response: pslverr=1, prdata=0. No cpuif request is issued.
- REQ:
  - cpuif_req=1 with the captured fields; cpuif_wr_biten is all ones.
  - Accepted on an edge where the stall matching req_is_wr is 0. At that edge cpuif_req drops, the counter clears, and the state goes to WAIT.
  - While stalled, the request is held unchanged with no timeout.
  - An ack arriving on the accepting edge itself completes the transfer: go straight to RESP.
- WAIT:
  - Only the ack matching req_is_wr is honoured; the opposite ack is ignored.
  - On ack: latch rd_data (reads only; writes return prdata=0) and rd_err/wr_err, then go to RESP.
  - If TIMEOUT_CYCLES>0 and the counter reaches TIMEOUT_CYCLES with no ack: go to RESP with pslverr=1 and prdata=0. A late ack is then ignored.
- RESP:
  - pready=1 for exactly one cycle, with pslverr and prdata valid, then return to IDLE.
  - prdata and pslverr return to 0 on the following edge.
- Minimum latency (ack in the accept cycle): setup edge T0, cpuif_req high in cycle T0+1, pready high in cycle T0+2. The APB transfer takes 3 cycles.
- The master must not drop psel mid-transfer; if it does, the bridge still completes the cpuif transaction and pulses pready.
- Acks received in IDLE or REQ (before acceptance) are ignored.
- Reset asserted mid-transfer abandons the transaction immediately; any ack after reset release is ignored.

Test Plan:
- Write 0x10 = 0xDEADBEEF, no stall, ack in the accept cycle -> cpuif_req for 1 cycle with addr 0x10, wr_data 0xDEADBEEF, biten 0xFFFFFFFF; pready 1 cycle at T0+2; pslverr=0.
- Read 0x13, stall_rd for 3 cycles, rd_ack 2 cycles after acceptance with 0x12345678 -> cpuif_addr=0x10, req held 4 cycles, prdata=0x12345678, pslverr=0.
- Read with rd_ack and rd_err=1 -> pready=1, pslverr=1; write with wr_ack and wr_err=1 -> pslverr=1, prdata=0.
- TIMEOUT_CYCLES=4, read with no ack -> pready and pslverr asserted exactly 5 cycles after acceptance with prdata=0; a rd_ack 2 cycles later changes nothing.
- psel and penable asserted together from IDLE -> no cpuif_req; pready=1 and pslverr=1 on the next cycle.
- arst_n pulsed low while in WAIT -> all outputs 0; a subsequent ack is ignored; the next write completes normally.
